// File: rtl/avalon_mem_bridge.sv
// Bridges single load/store requests from the core onto an Avalon-MM master port.
// Holds each request across waitrequest, returns read data and aborts on a wait timeout.
module avalon_mem_bridge #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] core_address,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [3:0]  core_byteenable,
  input  logic [31:0] core_writedata,
  output logic [31:0] core_readdata,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_timeout,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      address_d, writedata_d, readdata_d;
  logic [3:0]       byteenable_d;
  logic             read_d, write_d, done_d, timeout_d;

  // Stall is combinational so the sequencer freezes in the same cycle it raises a request
  assign core_stall = (state_q == BUS) || ((state_q == IDLE) && (core_read || core_write));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    address_d    = avm_address;
    read_d       = avm_read;
    write_d      = avm_write;
    byteenable_d = avm_byteenable;
    writedata_d  = avm_writedata;
    readdata_d   = core_readdata;
    done_d       = 1'b0;
    timeout_d    = core_timeout;

    case (state_q)
      IDLE: begin
        if (core_read || core_write) begin
          // A write with no enabled lanes has nothing to put on the bus
          if (core_write && (core_byteenable == 4'b0000)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = BUS;
            cnt_d        = '0;
            address_d    = core_address & 32'hFFFF_FFFC;
            write_d      = core_write;
            read_d       = ~core_write;
            byteenable_d = core_write ? core_byteenable : 4'b1111;
            writedata_d  = core_writedata;
          end
        end
      end
      BUS: begin
        if (!avm_waitrequest) begin
          if (avm_read) begin
            readdata_d = avm_readdata;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          read_d    = 1'b0;
          write_d   = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = DONE;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus strobes immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      core_readdata  <= '0;
      core_done      <= 1'b0;
      core_timeout   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      avm_address    <= address_d;
      avm_read       <= read_d;
      avm_write      <= write_d;
      avm_byteenable <= byteenable_d;
      avm_writedata  <= writedata_d;
      core_readdata  <= readdata_d;
      core_done      <= done_d;
      core_timeout   <= timeout_d;
    end
  end

endmodule

// File: doc/avalon_mem_bridge.md
Name: avalon_mem_bridge

Overview:
- Sits directly downstream of load_store, between the core's memory request signals and the Avalon-MM master port.
- Registers each core request and drives a single Avalon read or write.
- Holds that request across waitrequest and stalls the core's state sequencer until the bus completes.
- Returns captured read data with a one-cycle done pulse, and aborts with a timeout flag if the slave never responds.

Parameters:
- MAX_WAIT, 255, maximum consecutive cycles with waitrequest high before the transfer is aborted (must be at least 1).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
core_address  input  32  byte address from load_store (mem_address)
core_read  input  1  read request (mem_readenable)
core_write  input  1  write request (mem_writeenable)
core_byteenable  input  4  byte lanes (mem_byteenable)
core_writedata  input  32  store data (mem_writedata)
core_readdata  output  32  captured read data (to load_store mem_readdata)
core_stall  output  1  high: sequencer must hold its state
core_done  output  1  one-cycle pulse: transfer finished
core_timeout  output  1  sticky: a transfer was aborted on timeout
avm_address  output  32  word-aligned Avalon address
avm_read  output  1  Avalon read
avm_write  output  1  Avalon write
avm_byteenable  output  4  Avalon byte enables
avm_writedata  output  32  Avalon write data
avm_readdata  input  32  Avalon read data
avm_waitrequest  input  1  Avalon slave stall

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - All outputs are 0: avm_*, core_readdata, core_done, core_timeout.
  - Wait counter is 0.
  - Any in-flight bus transfer is abandoned immediately; avm_read/avm_write drop without waiting for a clock edge.
- FSM states IDLE, BUS, DONE.
- IDLE:
  - On a rising edge with core_read|core_write=1, latch the request and go to BUS.
  - avm_address is {core_address[31:2],2'b00}.
  - avm_byteenable is core_byteenable, forced to 4'b1111 for reads.
  - avm_writedata is core_writedata.
  - avm_read/avm_write are registered: they go high in the first BUS cycle.
- Simultaneous core_read and core_write: write wins and avm_read stays 0.
- Write with core_byteenable=4'b0000: no bus cycle is issued; go IDLE->DONE directly.
- BUS:
  - avm_* outputs are held constant while avm_waitrequest=1.
  - On an edge with avm_waitrequest=0:
    - Reads capture avm_readdata into core_readdata.
    - avm_read/avm_write clear to 0.
    - Counter clears.
    - Go to DONE.
  - On an edge with avm_waitrequest=1:
    - Counter increments.
    - If counter reaches MAX_WAIT, clear avm_read/avm_write, set core_timeout, leave core_readdata unchanged, and go to DONE.
- DONE: core_done=1 for exactly this cycle, then unconditional return to IDLE. A request present in DONE is ignored and is sampled again in IDLE.
- core_stall (combinational):
  - 1 in BUS.
  - 1 in IDLE while core_read|core_write=1.
  - 0 in DONE and otherwise.
- Latency: with zero wait states, request cycle -> BUS cycle -> DONE cycle; core_stall is high 2 cycles. Each waitrequest cycle adds exactly one cycle.
- core_readdata holds its value until the next completed read.
- core_timeout clears only on reset.
- Core inputs may change during BUS without effect, because they were latched in IDLE.

Test Plan:
1. Zero-wait read:
   - Stimulus: core_address=0x0000_0013, core_read=1, avm_waitrequest=0, avm_readdata=0xF987_6543.
   - Required: avm_address=0x0000_0010, avm_byteenable=4'b1111, avm_read high 1 cycle, core_stall high 2 cycles, core_done in cycle 3, core_readdata=0xF987_6543.
2. Write with 3 wait states:
   - Stimulus: core_write=1, core_address=0x20, core_byteenable=4'b0011, core_writedata=0x0000_BEEF, waitrequest=1 for 3 edges.
   - Required: avm_write/avm_writedata/avm_byteenable stable for 4 cycles, core_stall high 5 cycles, single core_done.
3. Timeout:
   - Stimulus: MAX_WAIT=4, core_read=1, waitrequest stuck at 1.
   - Required: avm_read drops after 4 wait edges, core_timeout=1, core_done pulses, core_readdata keeps its previous value 0xF987_6543.
4. Simultaneous read+write, then byteenable 0:
   - Stimulus: both requests high; then a write with byteenable=4'b0000.
   - Required: write-only Avalon cycle for the first; the second causes no avm_write at all, and core_done occurs 1 cycle after the request.
5. Async reset mid-BUS:
   - Stimulus: reset_n=0 mid-cycle while avm_read=1 and waitrequest=1.
   - Required: avm_read=0 before the next edge, all outputs 0; after release, a new read completes normally.
6. Back-to-back requests:
   - Stimulus: core_read held high across DONE.
   - Required: the second avm_read starts one cycle after DONE, with no duplicate or lost transfer.
